// File: rtl/sfft_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sfft_pkg
// Brief   : Shared SFFT types and constants for the output-side reader.
// Revision: 1.0 - initial release
// ============================================================================
package sfft_pkg;

  localparam int SFFT_NFFT      = 256;
  localparam int SFFT_OUT_WIDTH = 24;
  localparam int SFFT_IDX_WIDTH = $clog2(SFFT_NFFT);

  typedef logic signed [SFFT_OUT_WIDTH-1:0] sfft_bin_t;
  typedef sfft_bin_t sfft_frame_t [SFFT_NFFT];

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/sfft_abs_sat.sv
`default_nettype none
// ============================================================================
// Module  : sfft_abs_sat
// Brief   : Combinational saturating absolute value of a two's-complement bin.
// Revision: 1.0 - initial release
// ============================================================================
module sfft_abs_sat #(
  parameter int WIDTH = 24
) (
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // Negate negative values; the most-negative value has no positive twin, so clamp it
  always_comb begin
    dout = din;
    if (din == MOST_NEG) begin
      dout = MOST_POS;
    end else if (din[WIDTH-1]) begin
      dout = -din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfft_bin_reader.sv
`default_nettype none
// ============================================================================
// Module  : sfft_bin_reader
// Brief   : Captures SFFT result frames into an active/pending bank pair and
//           streams the lower BINS_OUT bins over a valid/ready interface.
// Revision: 1.0 - initial release
// ============================================================================
module sfft_bin_reader
  import sfft_pkg::*;
#(
  parameter int NFFT           = SFFT_NFFT,
  parameter int OUT_WIDTH      = SFFT_OUT_WIDTH,
  parameter int BINS_OUT       = NFFT / 2,
  parameter int ABS_OUTPUT     = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic signed [OUT_WIDTH-1:0]     sfft_in [NFFT],
  input  logic                            sfft_valid,
  input  logic                            flush,
  output logic signed [OUT_WIDTH-1:0]     bin_data,
  output logic [$clog2(NFFT)-1:0]         bin_index,
  output logic                            bin_first,
  output logic                            bin_last,
  output logic                            bin_valid,
  input  logic                            bin_ready,
  output logic                            frame_dropped,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

  localparam int              IDX_W    = $clog2(NFFT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS_OUT - 1);

  reader_state_t              state, state_nxt;
  logic [IDX_W-1:0]           idx, idx_nxt;
  logic                       pending_full, pending_full_nxt;
  logic                       sfft_valid_d;

  logic signed [OUT_WIDTH-1:0] active_bank  [NFFT];
  logic signed [OUT_WIDTH-1:0] pending_bank [NFFT];

  logic cap, xfer, at_last;
  logic load_active_in, load_active_pend, load_pending, drop;

  logic signed [OUT_WIDTH-1:0] raw_bin, conv_bin;

  assign cap     = sfft_valid & ~sfft_valid_d;
  assign xfer    = (state == STREAM) & bin_ready;
  assign at_last = (idx == LAST_IDX);

  // Next-state and bank-load decisions; flush overrides capture and transfer
  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    pending_full_nxt = pending_full;
    load_active_in   = 1'b0;
    load_active_pend = 1'b0;
    load_pending     = 1'b0;
    drop             = 1'b0;
    if (flush) begin
      state_nxt        = IDLE;
      pending_full_nxt = 1'b0;
      idx_nxt          = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cap) begin
            load_active_in = 1'b1;
            idx_nxt        = '0;
            state_nxt      = STREAM;
          end
        end
        STREAM: begin
          if (xfer && at_last) begin
            if (pending_full) begin
              load_active_pend = 1'b1;
              idx_nxt          = '0;
              if (cap) begin
                load_pending = 1'b1;
              end else begin
                pending_full_nxt = 1'b0;
              end
            end else if (cap) begin
              load_active_in = 1'b1;
              idx_nxt        = '0;
            end else begin
              state_nxt = IDLE;
              idx_nxt   = '0;
            end
          end else begin
            if (xfer) begin
              idx_nxt = idx + 1'b1;
            end
            if (cap) begin
              if (!pending_full) begin
                load_pending     = 1'b1;
                pending_full_nxt = 1'b1;
              end else begin
                drop = 1'b1;
              end
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Control registers, edge detector and saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      pending_full  <= 1'b0;
      sfft_valid_d  <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      pending_full  <= pending_full_nxt;
      sfft_valid_d  <= sfft_valid;
      frame_dropped <= drop;
      if (drop && (drop_count != {DROP_CNT_WIDTH{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  // Frame banks hold data only, so they carry no reset
  always_ff @(posedge clk) begin
    if (load_active_in) begin
      active_bank <= sfft_in;
    end else if (load_active_pend) begin
      active_bank <= pending_bank;
    end
    if (load_pending) begin
      pending_bank <= sfft_in;
    end
  end

  assign raw_bin = active_bank[idx];

  generate
    if (ABS_OUTPUT != 0) begin : g_abs
      sfft_abs_sat #(
        .WIDTH (OUT_WIDTH)
      ) u_abs (
        .din  (raw_bin),
        .dout (conv_bin)
      );
    end else begin : g_raw
      assign conv_bin = raw_bin;
    end
  endgenerate

  // Outputs are gated by state so reset forces them to zero at once
  assign bin_valid = (state == STREAM);
  assign bin_data  = bin_valid ? conv_bin : '0;
  assign bin_index = idx;
  assign bin_first = bin_valid & (idx == '0);
  assign bin_last  = bin_valid & at_last;

endmodule
`default_nettype wire

// File: tb/tb_sfft_bin_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_sfft_bin_reader
// Brief   : Directed self-checking bench for sfft_bin_reader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sfft_bin_reader;
  import sfft_pkg::*;

  localparam int N = 256;
  localparam int W = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  sfft_bin_t   sfft_in [N];
  logic        sfft_valid, flush, bin_ready, raw_ready;

  logic [W-1:0] bin_data, raw_data;
  logic [7:0]   bin_index, raw_index;
  logic         bin_first, bin_last, bin_valid, frame_dropped;
  logic         raw_first, raw_last, raw_valid, raw_dropped;
  logic [15:0]  drop_count, raw_drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sfft_bin_reader #(
    .NFFT(N), .OUT_WIDTH(W), .BINS_OUT(128), .ABS_OUTPUT(1), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sfft_in(sfft_in), .sfft_valid(sfft_valid),
    .flush(flush), .bin_data(bin_data), .bin_index(bin_index),
    .bin_first(bin_first), .bin_last(bin_last), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .frame_dropped(frame_dropped), .drop_count(drop_count)
  );

  sfft_bin_reader #(
    .NFFT(N), .OUT_WIDTH(W), .BINS_OUT(1), .ABS_OUTPUT(0), .DROP_CNT_WIDTH(16)
  ) dut_raw (
    .clk(clk), .reset_n(reset_n), .sfft_in(sfft_in), .sfft_valid(sfft_valid),
    .flush(flush), .bin_data(raw_data), .bin_index(raw_index),
    .bin_first(raw_first), .bin_last(raw_last), .bin_valid(raw_valid),
    .bin_ready(raw_ready), .frame_dropped(raw_dropped), .drop_count(raw_drop_count)
  );

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp_abs;
  } abs_vec_t;

  abs_vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] absi(input int v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

  initial begin
    int exp_idx, vcnt, e;

    tbl[0] = '{24'h800000, 24'h7FFFFF};
    tbl[1] = '{24'h7FFFFF, 24'h7FFFFF};
    tbl[2] = '{24'h800001, 24'h7FFFFF};
    tbl[3] = '{24'hFFFFFF, 24'h000001};
    tbl[4] = '{24'h000000, 24'h000000};
    tbl[5] = '{24'h000001, 24'h000001};
    tbl[6] = '{24'hFFCFC7, 24'h003039};
    tbl[7] = '{24'h123456, 24'h123456};

    reset_n = 1'b0; sfft_valid = 1'b0; flush = 1'b0; bin_ready = 1'b0; raw_ready = 1'b1;
    for (int k = 0; k < N; k++) sfft_in[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bin_valid), 0);
    chk("rst_data", 32'(bin_data), 0);
    chk("rst_index", 32'(bin_index), 0);
    chk("rst_first", 32'(bin_first), 0);
    chk("rst_last", 32'(bin_last), 0);
    chk("rst_dropped", 32'(frame_dropped), 0);
    chk("rst_dropcnt", 32'(drop_count), 0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("idle_valid", 32'(bin_valid), 0);

    // Basic stream: bins k-64, absolute value
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k - 64);
    bin_ready = 1'b1;
    sfft_valid = 1'b1;
    step();
    sfft_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("basic_valid", 32'(bin_valid), 1);
      chk("basic_index", 32'(bin_index), 32'(i));
      chk("basic_data", 32'(bin_data), absi(i - 64));
      chk("basic_first", 32'(bin_first), 32'(i == 0));
      chk("basic_last", 32'(bin_last), 32'(i == 127));
      step();
    end
    chk("basic_end_valid", 32'(bin_valid), 0);

    // Back-pressure: ready toggles every cycle
    bin_ready = 1'b0;
    sfft_valid = 1'b1;
    step();
    sfft_valid = 1'b0;
    exp_idx = 0;
    vcnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!bin_valid) break;
      vcnt++;
      bin_ready = (cyc % 2 == 1);
      chk("bp_index", 32'(bin_index), 32'(exp_idx));
      chk("bp_data", 32'(bin_data), absi(exp_idx - 64));
      if (bin_ready) exp_idx++;
      step();
    end
    chk("bp_valid_cycles", 32'(vcnt), 256);
    chk("bp_bins", 32'(exp_idx), 128);

    // Overflow: A active, B pending, C dropped
    bin_ready = 1'b0;
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k + 1000);
    sfft_valid = 1'b1; step(); sfft_valid = 1'b0; step();
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k + 2000);
    sfft_valid = 1'b1; step(); sfft_valid = 1'b0; step();
    chk("ovf_hold_index", 32'(bin_index), 0);
    chk("ovf_hold_data", 32'(bin_data), 1000);
    chk("ovf_no_drop_yet", 32'(frame_dropped), 0);
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k + 3000);
    sfft_valid = 1'b1; step();
    chk("ovf_drop_pulse", 32'(frame_dropped), 1);
    chk("ovf_drop_count", 32'(drop_count), 1);
    sfft_valid = 1'b0; step();
    chk("ovf_drop_end", 32'(frame_dropped), 0);
    chk("ovf_hold_data2", 32'(bin_data), 1000);
    for (int k = 0; k < N; k++) sfft_in[k] = W'(24'h0ABCDE);
    bin_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      e = (i < 128) ? (i + 1000) : (i - 128 + 2000);
      chk("ovf_valid", 32'(bin_valid), 1);
      chk("ovf_index", 32'(bin_index), 32'(i % 128));
      chk("ovf_data", 32'(bin_data), 32'(e));
      step();
    end
    chk("ovf_end_valid", 32'(bin_valid), 0);
    chk("ovf_count_keep", 32'(drop_count), 1);

    // Capture coincident with the last transfer, pending empty
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k * 2);
    sfft_valid = 1'b1; step(); sfft_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("edge_index_d", 32'(bin_index), 32'(i));
      chk("edge_data_d", 32'(bin_data), 32'(2 * i));
      if (i == 127) begin
        for (int k = 0; k < N; k++) sfft_in[k] = W'(k * 3 + 5);
        sfft_valid = 1'b1;
      end
      step();
    end
    sfft_valid = 1'b0;
    chk("edge_no_drop", 32'(frame_dropped), 0);
    for (int i = 0; i < 128; i++) begin
      chk("edge_valid_e", 32'(bin_valid), 1);
      chk("edge_index_e", 32'(bin_index), 32'(i));
      chk("edge_data_e", 32'(bin_data), 32'(3 * i + 5));
      step();
    end
    chk("edge_end_valid", 32'(bin_valid), 0);
    chk("edge_count_keep", 32'(drop_count), 1);

    // Saturation table, raw instance, held-high valid
    for (int k = 0; k < N; k++) sfft_in[k] = '0;
    for (int t = 0; t < 8; t++) sfft_in[t] = tbl[t].din;
    sfft_valid = 1'b1;
    step();
    for (int i = 0; i < 128; i++) begin
      if (i == 4) sfft_valid = 1'b0;
      if (i < 8) chk("abs_table", 32'(bin_data), 32'(tbl[i].exp_abs));
      if (i == 0) begin
        chk("raw_data", 32'(raw_data), 32'h800000);
        chk("raw_valid", 32'(raw_valid), 1);
        chk("raw_first", 32'(raw_first), 1);
        chk("raw_last", 32'(raw_last), 1);
      end
      if (i == 1 || i == 6) chk("raw_single_capture", 32'(raw_valid), 0);
      step();
    end
    chk("held_single_frame", 32'(bin_valid), 0);
    chk("held_count_keep", 32'(drop_count), 1);

    // Flush at bin 40 with pending full
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k + 500);
    sfft_valid = 1'b1; step(); sfft_valid = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      chk("flush_index", 32'(bin_index), 32'(i));
      if (i == 10) begin
        for (int k = 0; k < N; k++) sfft_in[k] = W'(k + 600);
        sfft_valid = 1'b1;
      end
      if (i == 11) sfft_valid = 1'b0;
      if (i == 40) flush = 1'b1;
      step();
    end
    flush = 1'b0;
    chk("flush_valid", 32'(bin_valid), 0);
    chk("flush_index0", 32'(bin_index), 0);
    chk("flush_data0", 32'(bin_data), 0);
    step();
    chk("flush_pending_gone", 32'(bin_valid), 0);
    chk("flush_count_keep", 32'(drop_count), 1);
    for (int k = 0; k < N; k++) sfft_in[k] = W'(k + 700);
    sfft_valid = 1'b1; step(); sfft_valid = 1'b0;
    chk("restart_valid", 32'(bin_valid), 1);
    chk("restart_index", 32'(bin_index), 0);
    chk("restart_data", 32'(bin_data), 700);
    chk("restart_first", 32'(bin_first), 1);
    repeat (5) step();
    chk("restart_index5", 32'(bin_index), 5);

    // Asynchronous reset mid-stream
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bin_valid), 0);
    chk("arst_data", 32'(bin_data), 0);
    chk("arst_index", 32'(bin_index), 0);
    chk("arst_first", 32'(bin_first), 0);
    chk("arst_last", 32'(bin_last), 0);
    chk("arst_dropped", 32'(frame_dropped), 0);
    chk("arst_dropcnt", 32'(drop_count), 0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("arst_idle", 32'(bin_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfft_bin_reader.md
Name: sfft_bin_reader

Overview:
- Consumer at the output end of the SFFT pipeline. It captures each completed NFFT-wide real-component result frame when the pipeline pulses its output-valid signal.
- Holds up to two frames: one active bank being streamed and one pending bank.
- Streams the lower BINS_OUT bins one per transfer over a valid/ready interface to downstream peak-finding and fingerprint logic.
- Optionally converts each bin to absolute value, and counts frames dropped under back-pressure.

Parameters:
- NFFT, 256, FFT points per frame; must equal the global NFFT.
- OUT_WIDTH, 24, bin width; must equal the global SFFT output width.
- BINS_OUT, NFFT/2, bins streamed per frame (bins 0..BINS_OUT-1); range 1..NFFT.
- ABS_OUTPUT, 1, 1 = stream |bin| with saturation; 0 = stream the raw two's-complement value.
- DROP_CNT_WIDTH, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sfft_in  in  OUT_WIDTH x NFFT  unpacked array of SFFT real outputs
- sfft_valid  in  1  pipeline output-valid; nominally a 1-cycle pulse
- flush  in  1  synchronous abort: discard both banks, return to IDLE
- bin_data  out  OUT_WIDTH  current bin value
- bin_index  out  clog2(NFFT)  index of the current bin
- bin_first  out  1  high when bin_index==0
- bin_last  out  1  high when bin_index==BINS_OUT-1
- bin_valid  out  1  bin_data/bin_index are valid
- bin_ready  in  1  downstream accepts the bin
- frame_dropped  out  1  1-cycle pulse when a frame is discarded
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped frames

Behaviour:
- Reset (async assert, sync release) sets: state=IDLE, idx=0, pending_full=0, sfft_valid_d=0, bin_valid=0, bin_first=0, bin_last=0, bin_index=0, bin_data=0, frame_dropped=0, drop_count=0. Bank contents are not reset.
- Capture event: cap = sfft_valid & ~sfft_valid_d. This is rising-edge detection, so a held-high sfft_valid yields exactly one capture.
- xfer = bin_valid & bin_ready.
- States are IDLE and STREAM. bin_valid=1 exactly when state==STREAM.
- IDLE:
  - cap: active<=sfft_in, idx<=0, go to STREAM.
  - bin_valid rises on the cycle after the capture edge (capture-to-first-bin latency 1 cycle).
- STREAM, no xfer on the last bin:
  - xfer: idx<=idx+1.
  - cap with pending empty: pending<=sfft_in, pending_full<=1.
  - cap with pending full: discard the new frame, pulse frame_dropped, drop_count++ (saturating at all-ones).
- STREAM, xfer with idx==BINS_OUT-1 (end of frame), resolved in priority order:
  - pending_full: active<=pending, idx<=0, stay in STREAM. If cap in the same cycle, pending<=sfft_in and pending_full stays 1 (no drop). Otherwise pending_full<=0.
  - pending empty and cap: active<=sfft_in directly, idx<=0, stay in STREAM, no bubble.
  - otherwise go to IDLE; bin_valid drops the next cycle.
- Output stability: bin_data is derived from the registered active bank and idx. While bin_valid & ~bin_ready, all outputs hold constant, even if a capture lands in the pending bank.
- Absolute value (ABS_OUTPUT=1): bin_data = x<0 ? -x : x. The most-negative value saturates to 2^(OUT_WIDTH-1)-1.
- flush:
  - Highest priority over cap/xfer in the same cycle: state<=IDLE, pending_full<=0, idx<=0.
  - Does not change drop_count.
  - The captured-edge register still updates, so a pulse coincident with flush is lost.
- Reset mid-stream: the partial frame is abandoned; downstream sees bin_valid fall asynchronously.
- BINS_OUT==1: bin_first and bin_last are both high on every transfer.

Decomposition:
- Shared package sfft_pkg:
  - localparams derived from the global NFFT/OUT_WIDTH;
  - typedef sfft_bin_t (logic signed [OUT_WIDTH-1:0]);
  - typedef sfft_frame_t (sfft_bin_t [NFFT]);
  - typedef enum reader_state_t {IDLE, STREAM}.
- One natural sub-module: sfft_abs_sat, a combinational saturating absolute value, instantiated on the bin mux output.
- Control and the two banks stay in the top.

Test Plan:
- Basic stream: sfft_in[k]=k-64, pulse sfft_valid, bin_ready=1, ABS_OUTPUT=1, BINS_OUT=128 -> bin_valid rises 1 cycle later; bins 0..127 stream on consecutive cycles with values 64,63,...,0,1,...,63; bin_first on idx0, bin_last on idx127; then IDLE.
- Back-pressure: toggle bin_ready every other cycle -> each bin is held stable while not ready; all 128 bins are delivered in order; 256 cycles of bin_valid.
- Overflow: bin_ready=0; pulse frames A, B, C -> B is pending; C produces a frame_dropped pulse and drop_count=1. Release ready -> A is streamed fully, then B back-to-back with no idle cycle.
- Simultaneous edge: cap exactly on A's last xfer with pending empty -> the next cycle shows the new frame at bin_index=0 with no bubble and no drop.
- Saturation/raw: bin0=0x800000 with ABS_OUTPUT=1 -> 0x7FFFFF; with ABS_OUTPUT=0 -> 0x800000. sfft_valid held high for 5 cycles -> exactly one frame is captured.
- Flush/reset: flush at bin 40 with pending full -> bin_valid is 0 next cycle and the next pulse restarts at bin 0. Assert reset_n low mid-stream -> all outputs 0 immediately; drop_count=0.
